// File: rtl/fifo_packet_reader_pkg.sv
// Shared types and width helpers for the commit-FIFO packet reader.
package fifo_stream_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } rd_state_e;

  localparam int unsigned LP_SKID_DEPTH = 32'd2;

  // A skid entry carries payload plus the last and user sideband bits.
  function automatic int unsigned beat_width(input int unsigned data_width);
    return data_width + 32'd2;
  endfunction

  function automatic int unsigned beat_cnt_width(input int unsigned max_beats);
    return $clog2(max_beats + 32'd1);
  endfunction

endpackage

// File: rtl/fifo_packet_reader_if.sv
// FWFT FIFO read port plus AXI-Stream-style output of the packet reader.
interface fifo_packet_reader_if #(
  parameter int unsigned P_DATA_WIDTH = 32
);

  logic                    fifo_empty;
  logic [P_DATA_WIDTH:0]   fifo_data;
  logic                    fifo_rd_en;
  logic                    m_tvalid;
  logic                    m_tready;
  logic [P_DATA_WIDTH-1:0] m_tdata;
  logic                    m_tlast;
  logic                    m_tuser;

  modport master (
    input  fifo_empty, fifo_data, m_tready,
    output fifo_rd_en, m_tvalid, m_tdata, m_tlast, m_tuser
  );

  modport slave (
    output fifo_empty, fifo_data, m_tready,
    input  fifo_rd_en, m_tvalid, m_tdata, m_tlast, m_tuser
  );

endinterface

// File: rtl/fifo_packet_reader_axis_skid2.sv
// Generic two-entry valid/ready skid buffer; the head entry drives the outputs directly
// from flops, and the fill level is exported so producers can gate on registered state.
module axis_skid2 #(
  parameter int unsigned P_WIDTH = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  input  logic [P_WIDTH-1:0] i_s_data,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [P_WIDTH-1:0] o_m_data,
  output logic [1:0]         o_count
);

  logic [P_WIDTH-1:0] r_head;
  logic [P_WIDTH-1:0] r_tail;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  assign o_s_ready = (r_count != 2'd2);
  assign o_m_valid = (r_count != 2'd0);
  assign o_m_data  = r_head;
  assign o_count   = r_count;
  assign w_push    = i_s_valid && o_s_ready;
  assign w_pop     = o_m_valid && i_m_ready;

  // Storage and fill level; a simultaneous push and pop only happens with one entry held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= i_s_data;
          end else begin
            r_tail <= i_s_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_head <= i_s_data;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_packet_reader.sv
// Pops committed beats from the FWFT FIFO, enforces a maximum packet length by truncating
// and dropping the tail, and keeps saturating packet/truncation status counters.
module fifo_packet_reader
  import fifo_stream_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_MAX_BEATS  = 64,
  parameter int unsigned P_CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_packet_reader_if.master   bus,
  output logic [P_CNT_WIDTH-1:0] pkt_count,
  output logic [P_CNT_WIDTH-1:0] trunc_count
);

  localparam int unsigned         LP_BEAT_W = beat_width(P_DATA_WIDTH);
  localparam int unsigned         LP_BC_W   = beat_cnt_width(P_MAX_BEATS);
  localparam logic [LP_BC_W-1:0]  LP_MAX    = LP_BC_W'(P_MAX_BEATS);

  typedef struct packed {
    logic [P_DATA_WIDTH-1:0] payload;
    logic                    last;
    logic                    user;
  } beat_t;

  rd_state_e              r_state;
  logic [LP_BC_W-1:0]     r_beat_cnt;
  logic [P_CNT_WIDTH-1:0] r_pkt_count;
  logic [P_CNT_WIDTH-1:0] r_trunc_count;

  logic                   w_pop;
  logic                   w_fwd;
  logic                   w_src_last;
  logic                   w_at_max;
  logic                   w_pkt_evt;
  logic                   w_trunc_evt;
  logic                   w_skid_ready;
  logic [1:0]             w_skid_count;
  beat_t                  w_beat;
  beat_t                  w_head;
  logic [LP_BEAT_W-1:0]   w_skid_out;

  // Pop decision uses only registered state, so m_tready never reaches fifo_rd_en.
  assign w_pop      = rst_n && !bus.fifo_empty &&
                      ((r_state == DROP) || (w_skid_count < 2'd2));
  assign w_fwd      = w_pop && (r_state == PASS) && w_skid_ready;
  assign w_src_last = bus.fifo_data[P_DATA_WIDTH];
  assign w_at_max   = ((r_beat_cnt + LP_BC_W'(1)) == LP_MAX);

  // Tag the incoming beat: a real last wins over the length limit.
  always_comb begin
    w_beat.payload = bus.fifo_data[P_DATA_WIDTH-1:0];
    if (w_src_last) begin
      w_beat.last = 1'b1;
      w_beat.user = 1'b0;
    end else begin
      w_beat.last = w_at_max;
      w_beat.user = w_at_max;
    end
  end

  assign w_pkt_evt   = w_fwd && w_beat.last;
  assign w_trunc_evt = w_fwd && w_beat.user;

  axis_skid2 #(
    .P_WIDTH (LP_BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_s_valid (w_fwd),
    .o_s_ready (w_skid_ready),
    .i_s_data  (w_beat),
    .o_m_valid (bus.m_tvalid),
    .i_m_ready (bus.m_tready),
    .o_m_data  (w_skid_out),
    .o_count   (w_skid_count)
  );

  assign w_head      = beat_t'(w_skid_out);
  assign bus.m_tdata = w_head.payload;
  assign bus.m_tlast = w_head.last;
  assign bus.m_tuser = w_head.user;
  assign bus.fifo_rd_en = w_pop;

  // Packet FSM and per-packet beat counter; both hold while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PASS;
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      case (r_state)
        PASS: begin
          if (w_src_last) begin
            r_beat_cnt <= '0;
          end else if (w_at_max) begin
            r_beat_cnt <= '0;
            r_state    <= DROP;
          end else begin
            r_beat_cnt <= r_beat_cnt + LP_BC_W'(1);
          end
        end
        DROP: begin
          if (w_src_last) begin
            r_state <= PASS;
          end else begin
            r_state <= DROP;
          end
        end
        default: begin
          r_state    <= PASS;
          r_beat_cnt <= '0;
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  // Saturating status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count   <= '0;
      r_trunc_count <= '0;
    end else begin
      if (w_pkt_evt && (r_pkt_count != {P_CNT_WIDTH{1'b1}})) begin
        r_pkt_count <= r_pkt_count + P_CNT_WIDTH'(1);
      end else begin
        r_pkt_count <= r_pkt_count;
      end
      if (w_trunc_evt && (r_trunc_count != {P_CNT_WIDTH{1'b1}})) begin
        r_trunc_count <= r_trunc_count + P_CNT_WIDTH'(1);
      end else begin
        r_trunc_count <= r_trunc_count;
      end
    end
  end

  assign pkt_count   = r_pkt_count;
  assign trunc_count = r_trunc_count;

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Bench: packet-level scoreboard of forwarded beats, skid occupancy and status counters.
module tb_fifo_packet_reader;

  localparam int DW   = 32;
  localparam int MAXB = 64;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] trunc_count;

  fifo_packet_reader_if #(.P_DATA_WIDTH(DW)) bus ();

  fifo_packet_reader #(
    .P_DATA_WIDTH (DW),
    .P_MAX_BEATS  (MAXB),
    .P_CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .pkt_count   (pkt_count),
    .trunc_count (trunc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW:0] word;
    bit          fwd;
    bit          elast;
    bit          euser;
  } src_t;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    bit            user;
  } exp_t;

  src_t src_q[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   occ = 0;
  int   cyc = 0;
  int   acc_n = 0;
  int   first_acc = 0;
  int   last_acc = 0;
  int   rdy_lo_from = 1;
  int   rdy_lo_to = 0;
  int   mpkt = 0;
  int   mtrunc = 0;
  bit   saw_block = 1'b0;
  bit   last_user = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One packet of len beats; expected output derived from packet length alone.
  task automatic load_pkt(input int len, input int tag);
    src_t s;
    exp_t e;
    for (int i = 1; i <= len; i++) begin
      s.word  = {1'(i == len), 16'(tag), 16'(i)};
      s.fwd   = (i <= MAXB);
      s.elast = s.fwd && ((i == len) || (i == MAXB));
      s.euser = s.fwd && (i == MAXB) && (len > MAXB);
      src_q.push_back(s);
      if (s.fwd) begin
        e.data = s.word[DW-1:0];
        e.last = s.elast;
        e.user = s.euser;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    acc_n     = 0;
    saw_block = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (src_q.size() == 0 && exp_q.size() == 0 && occ == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 64'(done), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // FIFO/sink driver and per-cycle compare against the model.
  initial begin : compare_proc
    bit            pstall;
    logic [DW-1:0] pdata;
    bit            plast;
    bit            puser;
    bit            exp_rd;
    src_t          s;
    exp_t          e;
    pstall         = 1'b0;
    pdata          = '0;
    plast          = 1'b0;
    puser          = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.m_tready   = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      bus.m_tready   = !(cyc >= rdy_lo_from && cyc <= rdy_lo_to);
      bus.fifo_empty = (src_q.size() == 0);
      bus.fifo_data  = (src_q.size() != 0) ? src_q[0].word : '0;
      #2;
      if (!rst_n) begin
        chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("rst_tdata", 64'(bus.m_tdata), 64'd0);
        chk("rst_tlast", 64'(bus.m_tlast), 64'd0);
        chk("rst_tuser", 64'(bus.m_tuser), 64'd0);
        chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_trunc_count", 64'(trunc_count), 64'd0);
        occ    = 0;
        pstall = 1'b0;
      end else begin
        chk("tvalid", 64'(bus.m_tvalid), 64'(occ != 0));
        exp_rd = 1'b0;
        if (src_q.size() != 0) exp_rd = (!src_q[0].fwd) || (occ < 2);
        chk("rd_en", 64'(bus.fifo_rd_en), 64'(exp_rd));
        if (src_q.size() != 0 && !bus.fifo_rd_en) saw_block = 1'b1;
        chk("pkt_count", 64'(pkt_count), 64'(mpkt));
        chk("trunc_count", 64'(trunc_count), 64'(mtrunc));
        if (pstall) begin
          chk("stall_tvalid", 64'(bus.m_tvalid), 64'd1);
          chk("stall_tdata", 64'(bus.m_tdata), 64'(pdata));
          chk("stall_tlast", 64'(bus.m_tlast), 64'(plast));
          chk("stall_tuser", 64'(bus.m_tuser), 64'(puser));
        end
        if (bus.m_tvalid && bus.m_tready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(bus.m_tdata), 64'hffff_ffff_ffff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", 64'(bus.m_tdata), 64'(e.data));
            chk("tlast", 64'(bus.m_tlast), 64'(e.last));
            chk("tuser", 64'(bus.m_tuser), 64'(e.user));
          end
          occ--;
          acc_n++;
          if (acc_n == 1) first_acc = cyc;
          last_acc  = cyc;
          last_user = bus.m_tuser;
        end
        pstall = bus.m_tvalid && !bus.m_tready;
        pdata  = bus.m_tdata;
        plast  = bus.m_tlast;
        puser  = bus.m_tuser;
        if (bus.fifo_rd_en && src_q.size() != 0) begin
          s = src_q.pop_front();
          if (s.fwd) occ++;
          if (s.fwd && s.elast) begin
            if (mpkt < CMAX) mpkt++;
            if (s.euser && mtrunc < CMAX) mtrunc++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    bit got2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #4 rst_n = 1'b1;

    // 4-beat packet at full rate.
    start_test();
    load_pkt(4, 1);
    drain(200);
    chk("t1_beats", 64'(acc_n), 64'd4);
    chk("t1_consecutive", 64'(last_acc - first_acc), 64'd3);
    chk("t1_pkt_count", 64'(pkt_count), 64'd1);
    chk("t1_tuser", 64'(last_user), 64'd0);

    // Same packet with tready low for four cycles.
    start_test();
    rdy_lo_from = cyc + 2;
    rdy_lo_to   = cyc + 5;
    load_pkt(4, 2);
    drain(200);
    chk("t2_rd_en_blocked", 64'(saw_block), 64'd1);
    chk("t2_beats", 64'(acc_n), 64'd4);
    chk("t2_pkt_count", 64'(pkt_count), 64'd2);

    // Overlong packet: 64 forwarded, 6 dropped.
    start_test();
    load_pkt(70, 3);
    drain(400);
    chk("t3_beats", 64'(acc_n), 64'd64);
    chk("t3_last_tuser", 64'(last_user), 64'd1);
    chk("t3_pkt_count", 64'(pkt_count), 64'd3);
    chk("t3_trunc_count", 64'(trunc_count), 64'd1);

    // Exactly max length with real last.
    start_test();
    load_pkt(64, 4);
    drain(400);
    chk("t4_beats", 64'(acc_n), 64'd64);
    chk("t4_last_tuser", 64'(last_user), 64'd0);
    chk("t4_pkt_count", 64'(pkt_count), 64'd4);
    chk("t4_trunc_count", 64'(trunc_count), 64'd1);

    // Reset mid-packet with two beats buffered.
    start_test();
    rdy_lo_from = cyc + 1;
    rdy_lo_to   = cyc + 1000;
    load_pkt(10, 5);
    got2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (occ == 2) begin
        got2 = 1'b1;
        break;
      end
    end
    chk("t5_two_buffered", 64'(got2), 64'd1);
    @(negedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("t5_async_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("t5_async_tdata", 64'(bus.m_tdata), 64'd0);
    src_q.delete();
    exp_q.delete();
    mpkt        = 0;
    mtrunc      = 0;
    rdy_lo_from = 1;
    rdy_lo_to   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #4 rst_n = 1'b1;
    chk("t5_pkt_count_cleared", 64'(pkt_count), 64'd0);
    start_test();
    load_pkt(3, 6);
    drain(200);
    chk("t5_beats", 64'(acc_n), 64'd3);
    chk("t5_pkt_count", 64'(pkt_count), 64'd1);

    // 20 one-beat packets back to back; counter saturates.
    start_test();
    for (int p = 0; p < 20; p++) load_pkt(1, 16 + p);
    drain(200);
    chk("t6_beats", 64'(acc_n), 64'd20);
    chk("t6_consecutive", 64'(last_acc - first_acc), 64'd19);
    chk("t6_pkt_saturated", 64'(pkt_count), 64'd15);
    chk("t6_trunc_count", 64'(trunc_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
